// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: redirect input, instruction-memory read port and decode handshake.
// The master modport is the fetch unit; the slave modport is its environment.
interface instr_fetch_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic                  mem_rd_en;
    logic [31:0]           mem_rd_instr;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr;
    logic [ADDR_WIDTH-1:0] out_pc;

    modport master (
        input  redirect_valid, redirect_pc, mem_rd_instr, out_ready,
        output mem_rd_addr, mem_rd_en, out_valid, out_instr, out_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_rd_instr, out_ready,
        input  mem_rd_addr, mem_rd_en, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencer over a fixed 1-cycle memory, with an output
// register plus a 1-entry skid so decode backpressure never drops returning data.
module instr_fetch #(
    parameter int                    ADDR_WIDTH = 11,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 11'h000
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);
    typedef struct packed {
        logic [31:0]           instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    logic [ADDR_WIDTH-1:0] pc_q, fetch_addr, inflight_pc;
    logic                  inflight_q, out_valid_q, skid_valid_q;
    entry_t                out_q, skid_q, cap;
    logic                  accept, rd_en;
    logic [1:0]            occ, occ_after;

    always_comb begin
        accept     = out_valid_q & bus.out_ready;
        occ        = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q};
        occ_after  = occ - {1'b0, accept};
        fetch_addr = (bus.redirect_valid ? bus.redirect_pc : pc_q) & ~ADDR_WIDTH'(3);
        // A redirect flushes everything buffered, so it may always issue.
        rd_en      = !rst && (bus.redirect_valid || occ_after < 2'd2);
        cap        = '{instr: bus.mem_rd_instr, pc: inflight_pc};
    end

    assign bus.mem_rd_addr = fetch_addr;
    assign bus.mem_rd_en   = rd_en;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_q.instr;
    assign bus.out_pc      = out_q.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            inflight_q   <= 1'b0;
            inflight_pc  <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            inflight_q <= rd_en;
            if (rd_en) begin
                inflight_pc <= fetch_addr;
                pc_q        <= fetch_addr + ADDR_WIDTH'(4);
            end

            if (bus.redirect_valid) begin
                out_valid_q  <= 1'b0;
                skid_valid_q <= 1'b0;
            end else if (!out_valid_q || accept) begin
                // Skid is older than the returning word, so it drains first.
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= inflight_q;
                    if (inflight_q) skid_q <= cap;
                end else begin
                    out_valid_q <= inflight_q;
                    if (inflight_q) out_q <= cap;
                end
            end else if (inflight_q) begin
                skid_q       <= cap;
                skid_valid_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: directed scenarios followed by random
// backpressure/redirect/reset traffic, checked against an in-order program stream.
module tb_instr_fetch;
    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_WIDTH(AW)) ifc ();
    instr_fetch_if #(.ADDR_WIDTH(AW)) ifc2 ();

    instr_fetch #(.ADDR_WIDTH(AW), .RESET_PC(11'h000)) dut (
        .clk(clk), .rst(rst), .bus(ifc.master)
    );
    instr_fetch #(.ADDR_WIDTH(AW), .RESET_PC(11'h7F8)) dut2 (
        .clk(clk), .rst(rst), .bus(ifc2.master)
    );

    // Memory word k (byte address 4k) holds 0x1000_0000 + k.
    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'h1000_0000 + 32'(a[AW-1:2]);
    endfunction

    always @(posedge clk) if (ifc.mem_rd_en)  ifc.mem_rd_instr  <= mem_word(ifc.mem_rd_addr);
    always @(posedge clk) if (ifc2.mem_rd_en) ifc2.mem_rd_instr <= mem_word(ifc2.mem_rd_addr);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected program stream: consecutive words from the last restart point.
    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
    } exp_t;
    exp_t          exp_q[$];
    logic [AW-1:0] next_pc;

    task automatic refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back('{next_pc, mem_word(next_pc)});
            next_pc = next_pc + AW'(4);
        end
    endtask

    task automatic restart(input logic [AW-1:0] a);
        exp_q.delete();
        next_pc = a & ~AW'(3);
        refill();
    endtask

    int            since   = -1;
    logic [AW-1:0] tgt     = '0;
    logic          prev_rst = 1'b1;
    logic          hold    = 1'b0;
    logic [31:0]   h_instr;
    logic [AW-1:0] h_pc;
    exp_t          e;

    // Monitor/scoreboard: samples pre-edge values at each rising edge.
    always @(posedge clk) begin
        if (rst) chk("rd_en_in_reset", 32'(ifc.mem_rd_en), 32'd0);
        if (ifc.mem_rd_en) chk("addr_align", 32'(ifc.mem_rd_addr[1:0]), 32'd0);

        if (hold) begin
            chk("hold_valid", 32'(ifc.out_valid), 32'd1);
            chk("hold_instr", ifc.out_instr, h_instr);
            chk("hold_pc", 32'(ifc.out_pc), 32'(h_pc));
        end
        hold    = !rst && !ifc.redirect_valid && ifc.out_valid && !ifc.out_ready;
        h_instr = ifc.out_instr;
        h_pc    = ifc.out_pc;

        if (since >= 0) since++;
        if (since == 1) begin
            chk("gap_after_restart", 32'(ifc.out_valid), 32'd0);
        end else if (since == 2) begin
            chk("restart_valid", 32'(ifc.out_valid), 32'd1);
            chk("restart_pc", 32'(ifc.out_pc), 32'(tgt));
            since = -1;
        end

        if (!rst && ifc.out_valid && ifc.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: got pc %h with no expected entry", ifc.out_pc);
            end else begin
                e = exp_q.pop_front();
                checks--;
                chk("sb_pc", 32'(ifc.out_pc), 32'(e.pc));
                chk("sb_instr", ifc.out_instr, e.instr);
                refill();
            end
        end

        if (rst) begin
            exp_q.delete();
            since = -1;
        end else if (ifc.redirect_valid) begin
            restart(ifc.redirect_pc);
            tgt   = ifc.redirect_pc & ~AW'(3);
            since = 0;
        end else if (prev_rst) begin
            restart(11'h000);
            tgt   = 11'h000;
            since = 0;
        end
        prev_rst = rst;
    end

    logic [AW-1:0] wrap_seq [4];

    initial begin
        wrap_seq[0] = 11'h7F8; wrap_seq[1] = 11'h7FC; wrap_seq[2] = 11'h000; wrap_seq[3] = 11'h004;
        ifc.redirect_valid  = 1'b0; ifc.redirect_pc  = '0; ifc.out_ready  = 1'b1;
        ifc2.redirect_valid = 1'b0; ifc2.redirect_pc = '0; ifc2.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(ifc.out_valid), 32'd0);
        chk("reset_pc", 32'(ifc.out_pc), 32'd0);
        chk("reset_instr", ifc.out_instr, 32'd0);
        chk("reset_rd_en", 32'(ifc.mem_rd_en), 32'd0);

        // Reset release and streaming with out_ready held high.
        rst = 1'b0;
        #1;
        chk("first_rd_en", 32'(ifc.mem_rd_en), 32'd1);
        chk("first_addr", 32'(ifc.mem_rd_addr), 32'h000);
        chk("first_addr_wrap", 32'(ifc2.mem_rd_addr), 32'h7F8);
        @(negedge clk);
        chk("cycle1_no_valid", 32'(ifc.out_valid), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("stream_valid", 32'(ifc.out_valid), 32'd1);
            chk("stream_pc", 32'(ifc.out_pc), 32'(4 * k));
            chk("stream_instr", ifc.out_instr, 32'h1000_0000 + 32'(k));
            chk("wrap_valid", 32'(ifc2.out_valid), 32'd1);
            chk("wrap_pc", 32'(ifc2.out_pc), 32'(wrap_seq[k]));
            @(negedge clk);
        end

        // Backpressure until output and skid saturate.
        ifc.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("bp_rd_en_low", 32'(ifc.mem_rd_en), 32'd0);
        chk("bp_valid", 32'(ifc.out_valid), 32'd1);

        // Redirect while output and skid are both full.
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 11'h100;
        #1;
        chk("redir_rd_en", 32'(ifc.mem_rd_en), 32'd1);
        chk("redir_addr", 32'(ifc.mem_rd_addr), 32'h100);
        @(negedge clk);
        ifc.redirect_valid = 1'b0;
        ifc.out_ready      = 1'b1;
        chk("redir_flush", 32'(ifc.out_valid), 32'd0);
        @(negedge clk);
        chk("redir_pc0", 32'(ifc.out_pc), 32'h100);
        @(negedge clk);
        chk("redir_pc1", 32'(ifc.out_pc), 32'h104);

        // Misaligned redirect target.
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 11'h103;
        #1;
        chk("misalign_addr", 32'(ifc.mem_rd_addr), 32'h100);
        @(negedge clk);
        ifc.redirect_valid = 1'b0;
        @(negedge clk);
        chk("misalign_pc", 32'(ifc.out_pc), 32'h100);

        // One-cycle reset pulse during backpressure.
        ifc.out_ready = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pulse_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_pulse_instr", ifc.out_instr, 32'd0);
        chk("rst_pulse_pc", 32'(ifc.out_pc), 32'd0);
        rst = 1'b0;
        ifc.out_ready = 1'b1;
        #1;
        chk("rst_pulse_restart", 32'(ifc.mem_rd_addr), 32'h000);
        repeat (4) @(negedge clk);

        // Random traffic.
        repeat (3000) begin
            @(negedge clk);
            ifc.out_ready      = $urandom_range(0, 3) != 0;
            ifc.redirect_valid = $urandom_range(0, 19) == 0;
            ifc.redirect_pc    = AW'($urandom);
            rst                = $urandom_range(0, 149) == 0;
        end
        @(negedge clk);
        rst = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.out_ready      = 1'b1;
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
